// File: rtl/ps_preprocess_pipe.sv
// ps_preprocess_pipe: pops RGB pixels from the capture FIFO, applies a
// per-pixel mode (passthrough / greyscale / threshold / invert) and queues the
// results in an internal output FIFO. Reads are credit-limited so the output
// FIFO can never overflow and no pixel is ever dropped.
module ps_preprocess_pipe #(
  parameter int DATA_WIDTH      = 12,
  parameter int OBUF_ADDR_WIDTH = 9,
  parameter int THRESH_DEFAULT  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_mode,
  input  logic                      i_thresh_wr,
  input  logic [DATA_WIDTH/3-1:0]   i_thresh,
  output logic                      o_rd,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic                      i_empty,
  input  logic                      i_rd,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_empty,
  output logic [OBUF_ADDR_WIDTH:0]  o_count,
  output logic                      o_busy
);

  localparam int CW    = DATA_WIDTH / 3;
  localparam int AW    = OBUF_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = AW + 2;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_GREY   = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;

  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Weighted luma (2R + 5G + B) / 8; the sum fits CW+3 bits and the result
  // never exceeds the channel maximum, so no saturation is needed.
  function automatic logic [CW-1:0] grey_f(input logic [DATA_WIDTH-1:0] px);
    logic [CW+2:0] r, g, b, sum;
    r   = {3'b000, px[3*CW-1:2*CW]};
    g   = {3'b000, px[2*CW-1:CW]};
    b   = {3'b000, px[CW-1:0]};
    sum = (r << 1) + (g << 2) + g + b;
    return sum[CW+2:3];
  endfunction

  // Per-pixel transform selected by the mode that travelled with the pixel.
  function automatic logic [DATA_WIDTH-1:0] mode_f(input logic [DATA_WIDTH-1:0] px,
                                                   input logic [1:0] mode,
                                                   input logic [CW-1:0] thr);
    logic [CW-1:0]         grey;
    logic [DATA_WIDTH-1:0] res;
    grey = grey_f(px);
    case (mode)
      MODE_PASS:   res = px;
      MODE_GREY:   res = {3{grey}};
      MODE_THRESH: res = (grey >= thr) ? '1 : '0;
      default:     res = ~px;
    endcase
    return res;
  endfunction

  // Control state
  logic                  o_rd_q, o_rd_d;
  logic                  rd_hold_q, rd_hold_d;
  logic [1:0]            inflight_q, inflight_d;
  logic                  vld_p0_q, vld_p0_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic [CW-1:0]         thresh_q, thresh_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

  // Datapath state
  logic [1:0]            mode_p0_q, mode_p0_d;
  logic [1:0]            mode_p1_q, mode_p1_d;
  logic [DATA_WIDTH-1:0] pix_p1_q, pix_p1_d;
  logic [DATA_WIDTH-1:0] res_p2_q, res_p2_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          wr_en, rd_en;
  logic [SW-1:0] credit_sum;

  // Next-state logic: read issue, pipeline advance, inflight and FIFO bookkeeping.
  always_comb begin
    credit_sum = {1'b0, count_q} + SW'(inflight_q) + SW'(o_rd_q);
    rd_hold_d  = i_empty;
    o_rd_d     = !i_empty && !rd_hold_q && (credit_sum < SW'(DEPTH));

    // S0: pixel read issued, its mode is latched alongside
    vld_p0_d  = o_rd_q;
    mode_p0_d = i_mode;
    // S1: capture data returned by the capture FIFO
    vld_p1_d  = vld_p0_q;
    mode_p1_d = mode_p0_q;
    pix_p1_d  = i_data;
    // S2: compute result with the threshold in force this cycle
    vld_p2_d  = vld_p1_q;
    res_p2_d  = mode_f(pix_p1_q, mode_p1_q, thresh_q);

    thresh_d = i_thresh_wr ? i_thresh : thresh_q;

    case ({o_rd_q, vld_p2_q})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase

    wr_en    = vld_p2_q;
    rd_en    = i_rd && (count_q != '0);
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    o_data_d = rd_en ? mem[rd_ptr_q] : o_data_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset flushes in-flight pixels and FIFO state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_q     <= 1'b0;
      rd_hold_q  <= 1'b0;
      inflight_q <= 2'd0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      thresh_q   <= CW'(THRESH_DEFAULT);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      o_data_q   <= '0;
    end else begin
      o_rd_q     <= o_rd_d;
      rd_hold_q  <= rd_hold_d;
      inflight_q <= inflight_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      thresh_q   <= thresh_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      o_data_q   <= o_data_d;
    end
  end

  // Pipeline data registers; qualified by the valids, so no reset needed.
  always_ff @(posedge i_clk) begin
    mode_p0_q <= mode_p0_d;
    mode_p1_q <= mode_p1_d;
    pix_p1_q  <= pix_p1_d;
    res_p2_q  <= res_p2_d;
  end

  // Output FIFO storage; a write lands three cycles after its read issue.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= res_p2_q;
  end

  assign o_rd    = o_rd_q;
  assign o_data  = o_data_q;
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_busy  = (inflight_q != 2'd0);

endmodule
